// File: rtl/icache_nway_pkg.sv
// icache_nway_pkg: shared FSM states, default geometry and helpers for the N-way instruction cache
package icache_nway_pkg;
   typedef enum logic [1:0] {IDLE, REFILL, INSTALL, ABORT} state_e;
   localparam int ICACHE_RAM_ADDR_WIDTH = 18;
   localparam int ICACHE_SET_WIDTH = 6;
   localparam int ICACHE_OFFSET_WIDTH = 2;
   localparam int ICACHE_WAYS = 2;
   // A 1-way cache still needs a 1-bit victim pointer to keep vectors non-empty.
   function automatic int ptr_width(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one cache way -- valid/tag/data arrays for every set plus the tag match
// Ports: clk_in/rst_in (async active-high)/rdy_in (freeze) /flush_in (clear all valid bits);
//        rd_set/rd_tag/rd_word lookup address -> hit, vld (valid bit of the looked-up set), inst;
//        wr_en/wr_set/wr_tag/wr_line install a whole line.
module icache_way
   import icache_nway_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = ICACHE_RAM_ADDR_WIDTH,
   parameter int SET_WIDTH = ICACHE_SET_WIDTH,
   parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH,
   localparam int TW = RAM_ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH - 2,
   localparam int LW = 32 << OFFSET_WIDTH
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    flush_in,
   input  logic [SET_WIDTH-1:0]    rd_set,
   input  logic [TW-1:0]           rd_tag,
   input  logic [OFFSET_WIDTH-1:0] rd_word,
   input  logic                    wr_en,
   input  logic [SET_WIDTH-1:0]    wr_set,
   input  logic [TW-1:0]           wr_tag,
   input  logic [LW-1:0]           wr_line,
   output logic                    hit,
   output logic                    vld,
   output logic [31:0]             inst
);
   localparam int SETS = 1 << SET_WIDTH;
   logic [SETS-1:0] valid_q, valid_d;
   logic [TW-1:0]   tag_q [SETS];
   logic [LW-1:0]   data_q [SETS];
   always_comb begin
      valid_d = valid_q;
      if (rdy_in && wr_en) valid_d[wr_set] = 1'b1;
      if (rdy_in && flush_in) valid_d = '0;
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) valid_q <= '0;
      else valid_q <= valid_d;
   end
   // Tag and data need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk_in) begin
      if (rdy_in && wr_en) begin
         tag_q[wr_set] <= wr_tag;
         data_q[wr_set] <= wr_line;
      end
   end
   assign vld = valid_q[rd_set];
   assign hit = vld && (tag_q[rd_set] == rd_tag);
   assign inst = data_q[rd_set][{rd_word, 5'b0} +: 32];
endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with FIFO replacement and word-by-word line refill
// Ports: clk_in, rst_in (async active-high), rdy_in (global freeze), flush_in (invalidate all);
//        fetch side iu_to_ic_valid/iu_to_ic_pc -> ic_to_iu_ready/ic_to_iu_inst (combinational hit);
//        memory side ic_to_mc_valid/ic_to_mc_addr -> mc_to_ic_ready/mc_to_ic_inst (one word per pulse).
module icache_nway
   import icache_nway_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = ICACHE_RAM_ADDR_WIDTH,
   parameter int SET_WIDTH = ICACHE_SET_WIDTH,
   parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH,
   parameter int WAYS = ICACHE_WAYS
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush_in,
   input  logic        iu_to_ic_valid,
   input  logic [31:0] iu_to_ic_pc,
   output logic        ic_to_iu_ready,
   output logic [31:0] ic_to_iu_inst,
   output logic        ic_to_mc_valid,
   output logic [31:0] ic_to_mc_addr,
   input  logic        mc_to_ic_ready,
   input  logic [31:0] mc_to_ic_inst
);
   localparam int TW = RAM_ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH - 2;
   localparam int LNW = RAM_ADDR_WIDTH - OFFSET_WIDTH - 2;
   localparam int WORDS = 1 << OFFSET_WIDTH;
   localparam int SETS = 1 << SET_WIDTH;
   localparam int VW = ptr_width(WAYS);
   localparam logic [31:0] OFF_MASK = 32'((1 << (OFFSET_WIDTH + 2)) - 1);

   state_e                         state_q, state_d;
   logic [OFFSET_WIDTH-1:0]        cnt_q, cnt_d;
   logic [LNW-1:0]                 line_q, line_d;
   logic [VW-1:0]                  vic_q, vic_d;
   logic                           mcv_q, mcv_d;
   logic [31:0]                    mca_q, mca_d;
   logic [WORDS-1:0][31:0]         buf_q, buf_d;
   logic [SETS-1:0][VW-1:0]        ptr_q, ptr_d;
   logic [WAYS-1:0]                hit_w, vld_w;
   logic [31:0]                    inst_w [WAYS];
   logic                           hit, we;
   logic [31:0]                    inst;
   logic [VW-1:0]                  victim;
   logic [SET_WIDTH-1:0]           rd_set, wr_set;

   assign rd_set = iu_to_ic_pc[SET_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
   assign wr_set = line_q[SET_WIDTH-1:0];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(
         .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
         .SET_WIDTH(SET_WIDTH),
         .OFFSET_WIDTH(OFFSET_WIDTH)
      ) u_way (
         .clk_in(clk_in),
         .rst_in(rst_in),
         .rdy_in(rdy_in),
         .flush_in(flush_in),
         .rd_set(rd_set),
         .rd_tag(iu_to_ic_pc[RAM_ADDR_WIDTH-1:SET_WIDTH+OFFSET_WIDTH+2]),
         .rd_word(iu_to_ic_pc[OFFSET_WIDTH+1:2]),
         .wr_en(we && (vic_q == VW'(w))),
         .wr_set(wr_set),
         .wr_tag(line_q[LNW-1:SET_WIDTH]),
         .wr_line(buf_q),
         .hit(hit_w[w]),
         .vld(vld_w[w]),
         .inst(inst_w[w])
      );
   end

   // At most one way matches, so an OR of gated words is a correct mux.
   // The victim is the lowest-numbered invalid way, else the set's FIFO pointer.
   always_comb begin
      hit = |hit_w;
      inst = '0;
      victim = ptr_q[rd_set];
      for (int i = WAYS - 1; i >= 0; i--) begin
         inst = inst | (hit_w[i] ? inst_w[i] : 32'd0);
         victim = vld_w[i] ? victim : VW'(i);
      end
   end

   assign ic_to_iu_ready = iu_to_ic_valid && hit && (state_q == IDLE);
   assign ic_to_iu_inst = inst;
   assign ic_to_mc_valid = mcv_q;
   assign ic_to_mc_addr = mca_q;

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      line_d = line_q;
      vic_d = vic_q;
      mcv_d = mcv_q;
      mca_d = mca_q;
      buf_d = buf_q;
      ptr_d = ptr_q;
      we = 1'b0;
      if (rdy_in) begin
         case (state_q)
            IDLE: begin
               if (!flush_in && iu_to_ic_valid && !hit) begin
                  state_d = REFILL;
                  line_d = iu_to_ic_pc[RAM_ADDR_WIDTH-1:OFFSET_WIDTH+2];
                  vic_d = victim;
                  cnt_d = '0;
                  mcv_d = 1'b1;
                  mca_d = iu_to_ic_pc & ~OFF_MASK;
               end
            end
            REFILL: begin
               if (flush_in) begin
                  // A response in the flush cycle already closes the handshake.
                  state_d = mc_to_ic_ready ? IDLE : ABORT;
                  mcv_d = !mc_to_ic_ready;
               end else if (mc_to_ic_ready) begin
                  buf_d[cnt_q] = mc_to_ic_inst;
                  cnt_d = cnt_q + 1'b1;
                  mca_d = mca_q + 32'd4;
                  if (cnt_q == {OFFSET_WIDTH{1'b1}}) begin
                     state_d = INSTALL;
                     mcv_d = 1'b0;
                  end
               end
            end
            INSTALL: begin
               state_d = IDLE;
               we = !flush_in;
               ptr_d[wr_set] = (WAYS == 1) ? '0 : ptr_q[wr_set] + 1'b1;
            end
            ABORT: begin
               if (mc_to_ic_ready) begin
                  state_d = IDLE;
                  mcv_d = 1'b0;
               end
            end
         endcase
         if (flush_in) ptr_d = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q <= '0;
         line_q <= '0;
         vic_q <= '0;
         mcv_q <= 1'b0;
         mca_q <= '0;
         buf_q <= '0;
         ptr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         line_q <= line_d;
         vic_q <= vic_d;
         mcv_q <= mcv_d;
         mca_q <= mca_d;
         buf_q <= buf_d;
         ptr_q <= ptr_d;
      end
   end
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed plus randomized fetch traffic against a line-residency FIFO model of the cache
module tb_icache_nway;
   localparam int WAYS = 2;
   localparam int WORDS = 4;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        flush_in = 1'b0;
   logic        iu_to_ic_valid = 1'b0;
   logic [31:0] iu_to_ic_pc = '0;
   logic        ic_to_iu_ready;
   logic [31:0] ic_to_iu_inst;
   logic        ic_to_mc_valid;
   logic [31:0] ic_to_mc_addr;
   logic        mc_to_ic_ready = 1'b0;
   logic [31:0] mc_to_ic_inst = '0;

   int errors = 0;
   int checks = 0;
   logic [31:0] mem [4096];
   logic [13:0] res [$];

   icache_nway #(
      .RAM_ADDR_WIDTH(18),
      .SET_WIDTH(6),
      .OFFSET_WIDTH(2),
      .WAYS(WAYS)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .rdy_in(rdy_in),
      .flush_in(flush_in),
      .iu_to_ic_valid(iu_to_ic_valid),
      .iu_to_ic_pc(iu_to_ic_pc),
      .ic_to_iu_ready(ic_to_iu_ready),
      .ic_to_iu_inst(ic_to_iu_inst),
      .ic_to_mc_valid(ic_to_mc_valid),
      .ic_to_mc_addr(ic_to_mc_addr),
      .mc_to_ic_ready(mc_to_ic_ready),
      .mc_to_ic_inst(mc_to_ic_inst)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Residency model: each entry is a line number (pc[17:4]); its low 6 bits are the set.
   function automatic bit mhit(input logic [31:0] pc);
      for (int i = 0; i < res.size(); i++) if (res[i] == pc[17:4]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void minstall(input logic [31:0] pc);
      int n = 0;
      int first = -1;
      for (int i = 0; i < res.size(); i++) begin
         if (res[i][5:0] == pc[9:4]) begin
            n++;
            if (first < 0) first = i;
         end
      end
      if (n == WAYS) res.delete(first);
      res.push_back(pc[17:4]);
   endfunction

   task automatic flush_pulse();
      @(negedge clk_in);
      iu_to_ic_valid = 1'b0;
      flush_in = 1'b1;
      @(negedge clk_in);
      flush_in = 1'b0;
      res.delete();
   endtask

   // abort_kind: 0 none, 1 flush, 2 async reset, applied once abort_at words are accepted.
   task automatic fetch(input logic [31:0] pc, input bit fast, input int stall_at,
                        input int abort_kind, input int abort_at);
      logic [31:0] base;
      bit hit_exp;
      bit stalled;
      int k;
      int cyc;
      hit_exp = mhit(pc);
      base = pc & ~32'hF;
      @(negedge clk_in);
      iu_to_ic_valid = 1'b1;
      iu_to_ic_pc = pc;
      mc_to_ic_ready = 1'b0;
      #1;
      chk("lookup_ready", ic_to_iu_ready, hit_exp);
      chk("lookup_mcv", ic_to_mc_valid, 0);
      if (hit_exp) begin
         chk("hit_inst", ic_to_iu_inst, mem[pc[13:2]]);
         iu_to_ic_valid = 1'b0;
         return;
      end
      k = 0;
      cyc = 0;
      stalled = 1'b0;
      while (k < WORDS && cyc < 200) begin
         @(negedge clk_in);
         cyc++;
         if (k == stall_at && !stalled) begin
            stalled = 1'b1;
            rdy_in = 1'b0;
            mc_to_ic_ready = 1'b1;
            mc_to_ic_inst = 32'hDEAD_BEEF;
            for (int i = 0; i < 3; i++) begin
               chk("stall_mcv", ic_to_mc_valid, 1);
               chk("stall_addr", ic_to_mc_addr, base + 32'(4 * k));
               #1;
               chk("stall_ready", ic_to_iu_ready, 0);
               @(negedge clk_in);
            end
            rdy_in = 1'b1;
            mc_to_ic_ready = 1'b0;
         end
         chk("refill_mcv", ic_to_mc_valid, 1);
         chk("refill_addr", ic_to_mc_addr, base + 32'(4 * k));
         if (abort_kind == 1 && k == abort_at) begin
            flush_in = 1'b1;
            mc_to_ic_ready = 1'b0;
            @(negedge clk_in);
            flush_in = 1'b0;
            res.delete();
            for (int i = 0; i < 2; i++) begin
               chk("abort_mcv", ic_to_mc_valid, 1);
               chk("abort_addr", ic_to_mc_addr, base + 32'(4 * k));
               #1;
               chk("abort_ready", ic_to_iu_ready, 0);
               @(negedge clk_in);
            end
            iu_to_ic_valid = 1'b0;
            mc_to_ic_ready = 1'b1;
            @(negedge clk_in);
            mc_to_ic_ready = 1'b0;
            #1;
            chk("abort_idle_mcv", ic_to_mc_valid, 0);
            return;
         end
         if (abort_kind == 2 && k == abort_at) begin
            #2;
            rst_in = 1'b1;
            #1;
            chk("async_rst_mcv", ic_to_mc_valid, 0);
            chk("async_rst_addr", ic_to_mc_addr, 0);
            res.delete();
            iu_to_ic_valid = 1'b0;
            mc_to_ic_ready = 1'b0;
            @(negedge clk_in);
            rst_in = 1'b0;
            return;
         end
         mc_to_ic_ready = fast || ($urandom_range(0, 1) == 1);
         mc_to_ic_inst = mem[ic_to_mc_addr[13:2]];
         #1;
         chk("refill_ready", ic_to_iu_ready, 0);
         if (mc_to_ic_ready) k++;
      end
      if (k < WORDS) chk("refill_timeout", k, WORDS);
      @(negedge clk_in);
      cyc++;
      mc_to_ic_ready = 1'b0;
      #1;
      chk("install_mcv", ic_to_mc_valid, 0);
      chk("install_ready", ic_to_iu_ready, 0);
      @(negedge clk_in);
      cyc++;
      #1;
      minstall(pc);
      chk("fill_ready", ic_to_iu_ready, 1);
      chk("fill_inst", ic_to_iu_inst, mem[pc[13:2]]);
      if (fast) chk("miss_latency", cyc, WORDS + 2);
      iu_to_ic_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] pc;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      @(negedge clk_in);
      iu_to_ic_valid = 1'b1;
      iu_to_ic_pc = 32'h100;
      #1;
      chk("reset_ready", ic_to_iu_ready, 0);
      chk("reset_mcv", ic_to_mc_valid, 0);
      chk("reset_addr", ic_to_mc_addr, 0);
      iu_to_ic_valid = 1'b0;
      rst_in = 1'b0;
      fetch(32'h100, 1'b1, -1, 0, 0);
      fetch(32'h10C, 1'b0, -1, 0, 0);
      fetch(32'h500, 1'b0, -1, 0, 0);
      fetch(32'h900, 1'b0, -1, 0, 0);
      fetch(32'h504, 1'b0, -1, 0, 0);
      fetch(32'h100, 1'b0, -1, 0, 0);
      fetch(32'h2004, 1'b0, -1, 1, 1);
      fetch(32'h2004, 1'b0, -1, 0, 0);
      fetch(32'h3000, 1'b0, 1, 0, 0);
      fetch(32'h3008, 1'b0, -1, 0, 0);
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) flush_pulse();
         pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 2) * 8 + 1) << 4)
              | (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 3) == 0) pc = pc | 32'hFFFC_0000;
         fetch(pc, 1'b0, -1, 0, 0);
      end
      fetch(32'h100, 1'b0, -1, 0, 0);
      fetch(32'h1400, 1'b0, -1, 2, 2);
      fetch(32'h100, 1'b0, -1, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
